contador_rfwild_checker: RTL

- Receive-side companion of the contador_rfwild free-running counter.
- Samples the counter value each qualified cycle and locks onto the +1 mod 2^WIDTH sequence.
- Flags every sequence break and counts errors and wraps.
- Used on-chip as a built-in self-check of the counter output and as the DUV monitor on the RTL bench.

---
 rtl/contador_rfwild_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/contador_rfwild_checker.sv
// contador_rfwild_checker: receive-side sequence monitor for the contador_rfwild
// free-running counter. Locks onto the +1 mod 2^WIDTH sequence, flags every
// break once locked, and counts errors (saturating) and wraps (modulo).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, dominant over valid_in
//   contador_in  [WIDTH-1:0] count value under check
//   valid_in     qualifies contador_in; low holds all state
//   locked       high while in LOCKED
//   err_pulse    one-cycle pulse per mismatch seen in LOCKED
//   wrap_pulse   one-cycle pulse per correct max->0 transition seen in LOCKED
//   err_count    [ERR_W-1:0] saturating mismatch count
//   wrap_count   [ERR_W-1:0] wrap count, rolls over
module contador_rfwild_checker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned LOCK_COUNT    = 3,
    parameter int unsigned UNLOCK_ERRORS = 2,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] contador_in,
    input  logic             valid_in,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    // Run/miss counters only need to reach 15
    localparam int unsigned CNT_W = 4;

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};

    logic [0:0]       state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic             has_prev, has_prev_n;
    logic [CNT_W-1:0] run, run_n;
    logic [CNT_W-1:0] miss, miss_n;
    logic             locked_n, err_pulse_n, wrap_pulse_n;
    logic [ERR_W-1:0] err_count_n, wrap_count_n;

    logic             match_c;
    logic [CNT_W-1:0] run_inc_c, miss_inc_c;

    assign match_c    = (contador_in == prev + WIDTH'(1));
    assign run_inc_c  = run + CNT_W'(1);
    assign miss_inc_c = miss + CNT_W'(1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            prev       <= '0;
            has_prev   <= 1'b0;
            run        <= '0;
            miss       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            has_prev   <= has_prev_n;
            run        <= run_n;
            miss       <= miss_n;
            locked     <= locked_n;
            err_pulse  <= err_pulse_n;
            wrap_pulse <= wrap_pulse_n;
            err_count  <= err_count_n;
            wrap_count <= wrap_count_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        prev_n       = prev;
        has_prev_n   = has_prev;
        run_n        = run;
        miss_n       = miss;
        err_pulse_n  = 1'b0;
        wrap_pulse_n = 1'b0;
        err_count_n  = err_count;
        wrap_count_n = wrap_count;

        if (valid_in) begin
            // Always resync to the received value
            prev_n     = contador_in;
            has_prev_n = 1'b1;

            if (has_prev) begin
                case (state)
                    SEARCH: begin
                        if (match_c) begin
                            run_n = run_inc_c;
                            if (run_inc_c >= CNT_W'(LOCK_COUNT)) begin
                                state_n = LOCKED;
                                miss_n  = '0;
                            end
                        end else begin
                            run_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (match_c) begin
                            miss_n = '0;
                            if (prev == MAX_VAL) begin
                                wrap_pulse_n = 1'b1;
                                wrap_count_n = wrap_count + ERR_W'(1);
                            end
                        end else begin
                            err_pulse_n = 1'b1;
                            if (err_count != ERR_SAT) begin
                                err_count_n = err_count + ERR_W'(1);
                            end
                            miss_n = miss_inc_c;
                            if (miss_inc_c >= CNT_W'(UNLOCK_ERRORS)) begin
                                state_n = SEARCH;
                                run_n   = '0;
                                miss_n  = '0;
                            end
                        end
                    end
                    default: state_n = SEARCH;
                endcase
            end
        end

        locked_n = (state_n == LOCKED);
    end

endmodule
